psa_accum_ctrl: RTL

- Sequencer that owns one shared PSA_16bit instance (four 4-bit lane adders, per-lane wrap, single Error flag) and uses it to reduce a stream of 16-bit operands into one 16-bit accumulated result.
- Sits between an operand producer (valid/ready) and the PSA datapath.
- Drives the PSA A/B inputs, captures Sum/Error, and reports the result with a sticky error flag and a done pulse.

---
 rtl/psa_accum_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/psa_accum_ctrl.sv
// Sequencer reducing a 16-bit operand stream through an external PSA_16bit.
// Optional error-wrap counter output enabled by defining PSA_ERR_CNT_EN.
module psa_accum_ctrl #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    output logic             in_ready,
    output logic [15:0]      psa_a,
    output logic [15:0]      psa_b,
    input  logic [15:0]      psa_sum,
    input  logic             psa_err,
    output logic             busy,
    output logic             done,
    output logic [15:0]      result,
    output logic             err_flag
`ifdef PSA_ERR_CNT_EN
    ,
    output logic [3:0]       err_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACCUM,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] rem;
    logic [15:0]      acc;
    logic             hs;
    logic             go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        psa_b    = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nx = (len_q == LEN_W'(1)) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                psa_b    = in_data;
                if (in_valid && rem == LEN_W'(1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign hs = in_valid & in_ready;
    assign go = (state == IDLE) & start;

    // The first word is loaded directly; only later words go through the PSA.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            rem      <= '0;
            len_q    <= '0;
            err_flag <= 1'b0;
            done     <= 1'b0;
`ifdef PSA_ERR_CNT_EN
            err_cnt  <= '0;
`endif
        end else begin
            done <= (state == DONE);
            if (go) begin
                acc      <= '0;
                rem      <= '0;
                len_q    <= len;
                err_flag <= 1'b0;
`ifdef PSA_ERR_CNT_EN
                err_cnt  <= '0;
`endif
            end else if (hs && state == LOAD) begin
                acc <= in_data;
                rem <= len_q - LEN_W'(1);
            end else if (hs && state == ACCUM) begin
                acc      <= psa_sum;
                rem      <= rem - LEN_W'(1);
                err_flag <= err_flag | psa_err;
`ifdef PSA_ERR_CNT_EN
                if (psa_err && err_cnt != 4'hf) begin
                    err_cnt <= err_cnt + 4'd1;
                end
`endif
            end
        end
    end

    assign psa_a  = acc;
    assign result = acc;
    assign busy   = (state != IDLE);

endmodule
